eth_tx_arb: RTL and testbench
=============================

# eth_tx_arb

Transmit-side scheduler that shares the single `eth_tx` byte interface between several frame sources (AXI-fed frame buffer, test pattern generator, future ARP/ICMP responders). It grants one source at a time round-robin and forwards that source's bytes to `eth_tx`. It then issues the packet-ready strobe, waits for the transmission to finish on the wire, and enforces an inter-frame gap before the next grant. It sits in `Eth_Clk` domain between the sources and `eth_tx`, replacing the ad-hoc test sequencing at the top level.

## Interface
Parameters:
- `NUM_SRC`, 2: number of requesters (2..4).
- `MAX_LEN`, 1500: maximum bytes forwarded per frame.
- `MIN_LEN`, 46: minimum frame length; used only with padding compiled in.
- `IFG_CYCLES`, 48: idle cycles after `Tx_Busy` falls (96 bit times at 2 bits/clk).
- `TX_START_TO`, 255: cycles to wait for `Tx_Busy` to rise after the strobe.

Ports:
- `Clk` in 1: Ethernet reference clock; single clock domain.
- `Rstn` in 1: asynchronous active-low reset.
- `Src_Req` in NUM_SRC: per-source request level, held until grant.
- `Src_Gnt` out NUM_SRC: one-hot grant, registered.
- `Src_Byte` in 8*NUM_SRC: per-source byte; source i occupies bits [8i+7:8i].
- `Src_Valid` in NUM_SRC: byte valid.
- `Src_Last` in NUM_SRC: marks the final byte of the frame.
- `Src_Ready` out NUM_SRC: byte accepted when `Src_Valid & Src_Ready`.
- `Eth_Byte` out 8: to `eth_tx`.
- `Eth_Byte_Valid` out 1: to `eth_tx`.
- `Eth_Pkt_Rdy` out 1: one-cycle strobe to `eth_tx`.
- `Tx_Busy` in 1: `eth_tx` `Tx_En`.
- `Trunc_Err` out 1: one-cycle pulse when a frame is cut at `MAX_LEN`.
- `Tx_Timeout` out 1: one-cycle pulse when `TX_START_TO` expires.

## Operation
States: IDLE → STREAM → (PAD) → STROBE → WAIT_START → WAIT_END → IFG → IDLE.
- **IDLE**
  - If any `Src_Req` is set, select the first requester strictly after `last_gnt`, wrapping modulo NUM_SRC. `last_gnt` resets to NUM_SRC-1, so source 0 wins first.
  - Set `Src_Gnt` and `last_gnt`, clear the byte counter, go to STREAM.
- **STREAM**
  - `Src_Ready[g]` = (state==STREAM) & `Src_Gnt[g]`; combinational from registered state.
  - Each accepted byte: `Eth_Byte`/`Eth_Byte_Valid` registered one cycle later, counter +1.
  - Gaps (`Src_Valid` low) give `Eth_Byte_Valid` low; no other effect.
  - Accepted byte with `Src_Last`: go to PAD if padding is enabled and count+1 < MIN_LEN, else STROBE.
  - Accepted byte without last when count == MAX_LEN-1: treated as last, `Trunc_Err` pulses, grant drops. The source must abandon the rest of its frame when `Src_Gnt` falls.
- **PAD**: emit 0x00 bytes with `Eth_Byte_Valid` high, one per cycle, until count == MIN_LEN, then STROBE.
- **STROBE**: `Eth_Pkt_Rdy` high for exactly one cycle, in the cycle after the last `Eth_Byte_Valid`. `Src_Gnt` clears. Go to WAIT_START.
- **WAIT_START**
  - `Tx_Busy` high → WAIT_END.
  - Timer reaches TX_START_TO → `Tx_Timeout` pulses, go to IFG.
- **WAIT_END**: `Tx_Busy` low → IFG.
- **IFG**: count IFG_CYCLES, then IDLE. Requests are ignored; they stay pending.
- **Counter width**: byte counter is $clog2(MAX_LEN+1) bits. IFG and timeout timers share one $clog2(max(IFG_CYCLES,TX_START_TO)+1)-bit counter.

## Timing
- **Reset values**: all outputs 0, state IDLE, counters 0, `last_gnt` = NUM_SRC-1. Reset mid-frame aborts immediately with no strobe; `eth_tx` is reset by the same reset.
- **Request to grant**: `Src_Req` sampled high in IDLE gives `Src_Gnt` high on the next edge. `Src_Ready` rises with the grant.
- **Data latency**: accepted byte appears on `Eth_Byte` 1 cycle later.
- **Last byte to strobe**: last source byte accepted in cycle N gives `Eth_Byte_Valid` in N+1 and `Eth_Pkt_Rdy` in N+2 (no padding).
- **Strobe to next grant**: at least 1 + Tx_Busy duration + IFG_CYCLES + 1 cycles.
- **Request withdrawal**: `Src_Req` dropping while the source is granted has no effect; the source must complete or the frame is truncated.
- **Simultaneous requests**: all sources requesting continuously are served 0,1,..,NUM_SRC-1,0.

## Configuration
- `ETH_TX_ARB_PAD_EN` defined: PAD state compiled in; short frames are zero-padded to MIN_LEN bytes.
- Macro undefined: the PAD state and its logic are absent. Last byte goes directly to STROBE and frames shorter than MIN_LEN pass unpadded.

## Structure
- Shared package `eth_pkg`:
  - state encoding constants;
  - default MIN_LEN/MAX_LEN/IFG_CYCLES values, shared with `eth_tx` and `eth_rx`.
- One sub-module `rr_arbiter`: request vector plus last-grant pointer in, one-hot grant out; purely combinational with the pointer held in the parent. Mux and FSM stay in `eth_tx_arb`.

## Test plan
- **Single frame**: source 0 requests with a 40-byte frame (0x01..0x28). Expect `Eth_Byte` 0x01..0x28 contiguous, `Eth_Pkt_Rdy` 1 cycle after the last valid byte, no errors.
- **Round-robin**: both sources request at once with 60-byte frames. Expect grant order 0,1,0. The second grant comes exactly IFG_CYCLES+1 cycles after `Tx_Busy` falls.
- **Truncation**: MAX_LEN=64, source sends 80 bytes. Expect 64 bytes forwarded, one `Trunc_Err` pulse, `Src_Gnt` low after byte 64.
- **Padding on**: with `ETH_TX_ARB_PAD_EN`, a 10-byte frame yields 46 valid bytes with bytes 11..46 = 0x00. With the macro off, expect 10 bytes only.
- **Start timeout**: hold `Tx_Busy` low after the strobe. Expect `Tx_Timeout` pulse TX_START_TO cycles later, then IFG, then the next grant.
- **Reset mid-frame**: deassert `Rstn` at byte 20. All outputs 0 immediately, and the next frame after release is source 0 with a fresh count.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: definitions shared by the Ethernet transmit/receive blocks.
//   - arb_state_e : eth_tx_arb scheduler state encoding
//   - EthMinLen / EthMaxLen / EthIfgCycles : default frame limits, also used by eth_tx and eth_rx
//   - max_u() : elaboration-time helper for sizing shared counters
package eth_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStream,
    StPad,
    StStrobe,
    StWaitStart,
    StWaitEnd,
    StIfg
  } arb_state_e;

  localparam int unsigned EthMinLen    = 46;
  localparam int unsigned EthMaxLen    = 1500;
  localparam int unsigned EthIfgCycles = 48;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eth_tx_arb_if.sv
// eth_tx_arb_if: source-side handshake and eth_tx-side byte stream of the transmit scheduler.
//   master : the scheduler (drives grants, ready, byte stream, strobe and error pulses)
//   slave  : the frame sources plus eth_tx (drive requests, bytes, Tx_Busy)
// Source i occupies Src_Byte[8i+7:8i].
interface eth_tx_arb_if #(
  parameter int unsigned NUM_SRC = 2
);
  logic [NUM_SRC-1:0]   Src_Req;
  logic [NUM_SRC-1:0]   Src_Gnt;
  logic [8*NUM_SRC-1:0] Src_Byte;
  logic [NUM_SRC-1:0]   Src_Valid;
  logic [NUM_SRC-1:0]   Src_Last;
  logic [NUM_SRC-1:0]   Src_Ready;
  logic [7:0]           Eth_Byte;
  logic                 Eth_Byte_Valid;
  logic                 Eth_Pkt_Rdy;
  logic                 Tx_Busy;
  logic                 Trunc_Err;
  logic                 Tx_Timeout;

  modport master (
    input  Src_Req, Src_Byte, Src_Valid, Src_Last, Tx_Busy,
    output Src_Gnt, Src_Ready, Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy, Trunc_Err, Tx_Timeout
  );

  modport slave (
    output Src_Req, Src_Byte, Src_Valid, Src_Last, Tx_Busy,
    input  Src_Gnt, Src_Ready, Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy, Trunc_Err, Tx_Timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Grants the first requester strictly after
// last_gnt_i, wrapping modulo NUM_SRC; the pointer itself lives in the parent.
//   req_i      : request vector
//   last_gnt_i : index of the previously granted source
//   gnt_o      : one-hot grant (zero when nobody requests)
//   gnt_idx_o  : index of the granted source
//   gnt_vld_o  : some source was granted
module rr_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   last_gnt_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    // off runs to NUM_SRC so the last-granted source itself is considered last
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      cand = IDX_W'((32'(last_gnt_i) + off) % NUM_SRC);
      if (!gnt_vld_o && req_i[cand]) begin
        gnt_vld_o   = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: transmit-side scheduler sharing the single eth_tx byte interface between
// NUM_SRC frame sources. Grants one source round-robin, forwards its bytes (1-cycle latency),
// strobes Eth_Pkt_Rdy, waits for Tx_Busy to rise and fall, then enforces the inter-frame gap.
//   Clk, Rstn : Ethernet clock, asynchronous active-low reset
//   bus       : eth_tx_arb_if.master - Src_Req/Gnt/Byte/Valid/Last/Ready per source,
//               Eth_Byte/Eth_Byte_Valid/Eth_Pkt_Rdy towards eth_tx, Tx_Busy from eth_tx,
//               Trunc_Err (frame cut at MAX_LEN), Tx_Timeout (Tx_Busy never rose)
// Build option: define ETH_TX_ARB_PAD_EN to zero-pad frames shorter than MIN_LEN.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned MAX_LEN     = EthMaxLen,
  parameter int unsigned MIN_LEN     = EthMinLen,
  parameter int unsigned IFG_CYCLES  = EthIfgCycles,
  parameter int unsigned TX_START_TO = 255
) (
  input logic         Clk,
  input logic         Rstn,
  eth_tx_arb_if.master bus
);

  localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  // Padding counts up to MIN_LEN, so the counter must also cover it
  localparam int unsigned CntW = $clog2(max_u(MAX_LEN, MIN_LEN) + 1);
  localparam int unsigned TmrW = $clog2(max_u(IFG_CYCLES, TX_START_TO) + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]    last_gnt_q, last_gnt_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [TmrW-1:0]    tmr_q, tmr_d;
  logic [7:0]         byte_q, byte_d;
  logic               byte_vld_q, byte_vld_d;
  logic               pkt_rdy_q, pkt_rdy_d;
  logic               trunc_q, trunc_d;
  logic               timeout_q, timeout_d;

  logic [NUM_SRC-1:0] arb_gnt;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_vld;
  logic [NUM_SRC-1:0] src_ready;
  logic [7:0]         sel_byte;
  logic               sel_last;
  logic               accept;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IdxW)
  ) u_rr_arbiter (
    .req_i      (bus.Src_Req),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (arb_gnt),
    .gnt_idx_o  (arb_idx),
    .gnt_vld_o  (arb_vld)
  );

  assign src_ready = (state_q == StStream) ? gnt_q : '0;
  assign accept    = |(bus.Src_Valid & src_ready);
  assign sel_last  = |(bus.Src_Last & gnt_q);

  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_q[i]) sel_byte = bus.Src_Byte[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    byte_d     = 8'h00;
    byte_vld_d = 1'b0;
    pkt_rdy_d  = 1'b0;
    trunc_d    = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_vld) begin
          gnt_d      = arb_gnt;
          last_gnt_d = arb_idx;
          cnt_d      = '0;
          state_d    = StStream;
        end
      end
      StStream: begin
        if (accept) begin
          byte_d     = sel_byte;
          byte_vld_d = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          // A frame reaching MAX_LEN without Src_Last is cut here; the source sees Src_Gnt fall
          if (sel_last || (cnt_q == CntW'(MAX_LEN - 1))) begin
            trunc_d = !sel_last;
            gnt_d   = '0;
            state_d = StStrobe;
`ifdef ETH_TX_ARB_PAD_EN
            if (32'(cnt_q) + 32'd1 < MIN_LEN) state_d = StPad;
`endif
          end
        end
      end
`ifdef ETH_TX_ARB_PAD_EN
      StPad: begin
        byte_vld_d = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (32'(cnt_q) + 32'd1 >= MIN_LEN) state_d = StStrobe;
      end
`endif
      StStrobe: begin
        // Registered, so the strobe lands one cycle after the last valid byte
        pkt_rdy_d = 1'b1;
        tmr_d     = '0;
        state_d   = StWaitStart;
      end
      StWaitStart: begin
        if (bus.Tx_Busy) begin
          state_d = StWaitEnd;
        end else if (32'(tmr_q) + 32'd1 >= TX_START_TO) begin
          timeout_d = 1'b1;
          tmr_d     = TmrW'(1);
          state_d   = StIfg;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StWaitEnd: begin
        // The cycle Tx_Busy is first seen low is the first gap cycle
        if (!bus.Tx_Busy) begin
          tmr_d   = TmrW'(1);
          state_d = StIfg;
        end
      end
      StIfg: begin
        if (32'(tmr_q) + 32'd1 >= IFG_CYCLES) begin
          tmr_d   = '0;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      last_gnt_q <= IdxW'(NUM_SRC - 1);
      cnt_q      <= '0;
      tmr_q      <= '0;
      byte_q     <= 8'h00;
      byte_vld_q <= 1'b0;
      pkt_rdy_q  <= 1'b0;
      trunc_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      pkt_rdy_q  <= pkt_rdy_d;
      trunc_q    <= trunc_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.Src_Gnt        = gnt_q;
  assign bus.Src_Ready      = src_ready;
  assign bus.Eth_Byte       = byte_q;
  assign bus.Eth_Byte_Valid = byte_vld_q;
  assign bus.Eth_Pkt_Rdy    = pkt_rdy_q;
  assign bus.Trunc_Err      = trunc_q;
  assign bus.Tx_Timeout     = timeout_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: directed bench for eth_tx_arb. A single bus-functional process models the
// two frame sources and eth_tx and logs what the scheduler emits; the main process applies
// the scenarios and compares against hand-computed values.
module tb_eth_tx_arb;

  localparam int unsigned NSrc      = 2;
  localparam int unsigned MaxLen    = 64;
  localparam int unsigned MinLen    = 46;
  localparam int unsigned IfgCycles = 48;
  localparam int unsigned TxStartTo = 30;
  localparam int          BusyLen   = 20;

  logic Clk = 1'b0;
  logic Rstn = 1'b0;
  always #5 Clk = ~Clk;

  eth_tx_arb_if #(.NUM_SRC(NSrc)) bus ();

  eth_tx_arb #(
    .NUM_SRC     (NSrc),
    .MAX_LEN     (MaxLen),
    .MIN_LEN     (MinLen),
    .IFG_CYCLES  (IfgCycles),
    .TX_START_TO (TxStartTo)
  ) dut (
    .Clk  (Clk),
    .Rstn (Rstn),
    .bus  (bus)
  );

  int n_vec, n_err;
  int cyc;

  // Source model state
  int         go_seq[NSrc];
  int         done_seq[NSrc];
  int         pos[NSrc];
  int         src_len[NSrc];
  logic [7:0] src_base[NSrc];
  bit         granted[NSrc];
  bit         gap_en[NSrc];
  bit         acc[NSrc];

  // eth_tx model state
  bit tx_auto;
  int tx_dly, tx_rem;

  // Observation log
  logic [7:0]      rx_q[$];
  int              gnt_log[$];
  int              gnt_cyc_q[$];
  int              tx_fall_q[$];
  int              first_vld_cyc, last_vld_cyc;
  int              pkt_cnt, pkt_cyc, pkt_lag;
  int              trunc_cnt, trunc_cyc, tmo_cnt, tmo_cyc, gnt_fall_cyc;
  logic [NSrc-1:0] gnt_prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rxb(input int i);
    return (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hffff_ffff;
  endfunction

  function automatic int glog(input int i);
    return (i < gnt_log.size()) ? gnt_log[i] : -1;
  endfunction

  function automatic int gcyc(input int i);
    return (i < gnt_cyc_q.size()) ? gnt_cyc_q[i] : -1;
  endfunction

  function automatic int fcyc(input int i);
    return (i < tx_fall_q.size()) ? tx_fall_q[i] : -1000;
  endfunction

  task automatic clr_mon();
    rx_q.delete();
    gnt_log.delete();
    gnt_cyc_q.delete();
    tx_fall_q.delete();
    first_vld_cyc = -1;
    last_vld_cyc  = -1;
    pkt_cnt       = 0;
    pkt_cyc       = -1;
    pkt_lag       = -1;
    trunc_cnt     = 0;
    trunc_cyc     = -1;
    tmo_cnt       = 0;
    tmo_cyc       = -1;
    gnt_fall_cyc  = -1;
  endtask

  task automatic do_reset();
    @(posedge Clk); #2;
    Rstn = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    Rstn = 1'b1;
    clr_mon();
  endtask

  task automatic wait_pkt(input int n, input int bound, input string tag);
    int k = 0;
    while (pkt_cnt < n && k < bound) begin
      @(posedge Clk); #2;
      k++;
    end
    if (pkt_cnt < n) check_eq(tag, pkt_cnt, n);
  endtask

  task automatic wait_rx(input int n, input int bound, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < bound) begin
      @(posedge Clk); #2;
      k++;
    end
    if (rx_q.size() < n) check_eq(tag, rx_q.size(), n);
  endtask

  task automatic wait_tmo(input int bound, input string tag);
    int k = 0;
    while (tmo_cnt < 1 && k < bound) begin
      @(posedge Clk); #2;
      k++;
    end
    if (tmo_cnt < 1) check_eq(tag, tmo_cnt, 1);
  endtask

  task automatic wait_gnts(input int n, input int bound, input string tag);
    int k = 0;
    while (gnt_log.size() < n && k < bound) begin
      @(posedge Clk); #2;
      k++;
    end
    if (gnt_log.size() < n) check_eq(tag, gnt_log.size(), n);
  endtask

  // Bus-functional model: monitor at posedge+1, drive sources/eth_tx, sample handshakes at negedge
  initial begin
    bus.Src_Req   = '0;
    bus.Src_Valid = '0;
    bus.Src_Last  = '0;
    bus.Src_Byte  = '0;
    bus.Tx_Busy   = 1'b0;
    cyc    = 0;
    tx_dly = 0;
    tx_rem = 0;
    gnt_prev = '0;
    for (int i = 0; i < NSrc; i++) begin
      done_seq[i] = 0;
      pos[i]      = 0;
      granted[i]  = 1'b0;
      acc[i]      = 1'b0;
    end
    forever begin
      @(posedge Clk); #1;
      cyc++;
      if (bus.Eth_Byte_Valid) begin
        if (rx_q.size() == 0) first_vld_cyc = cyc;
        rx_q.push_back(bus.Eth_Byte);
        last_vld_cyc = cyc;
      end
      if (bus.Eth_Pkt_Rdy) begin
        pkt_cnt++;
        pkt_cyc = cyc;
        pkt_lag = cyc - last_vld_cyc;
      end
      if (bus.Trunc_Err) begin
        trunc_cnt++;
        trunc_cyc = cyc;
      end
      if (bus.Tx_Timeout) begin
        tmo_cnt++;
        tmo_cyc = cyc;
      end
      for (int i = 0; i < NSrc; i++) begin
        if (bus.Src_Gnt[i] && !gnt_prev[i]) begin
          gnt_log.push_back(i);
          gnt_cyc_q.push_back(cyc);
        end
        if (!bus.Src_Gnt[i] && gnt_prev[i]) gnt_fall_cyc = cyc;
      end
      gnt_prev = bus.Src_Gnt;

      if (!Rstn) begin
        bus.Tx_Busy = 1'b0;
        tx_dly = 0;
        tx_rem = 0;
      end else begin
        if (tx_dly > 0) begin
          tx_dly--;
          if (tx_dly == 0) begin
            bus.Tx_Busy = 1'b1;
            tx_rem = BusyLen;
          end
        end else if (bus.Tx_Busy) begin
          tx_rem--;
          if (tx_rem == 0) begin
            bus.Tx_Busy = 1'b0;
            tx_fall_q.push_back(cyc);
          end
        end
        if (bus.Eth_Pkt_Rdy && tx_auto) tx_dly = 2;
      end

      for (int i = 0; i < NSrc; i++) begin
        if (acc[i]) pos[i]++;
        if (bus.Src_Gnt[i]) begin
          granted[i] = 1'b1;
        end else if (granted[i]) begin
          granted[i] = 1'b0;
          done_seq[i]++;
          pos[i] = 0;
        end
        bus.Src_Req[i] = !granted[i] && (go_seq[i] != done_seq[i]);
        if (granted[i] && pos[i] < src_len[i] && !(gap_en[i] && (cyc % 4 == 2))) begin
          bus.Src_Valid[i]       = 1'b1;
          bus.Src_Byte[8*i +: 8] = 8'(src_base[i] + pos[i]);
          bus.Src_Last[i]        = (pos[i] == src_len[i] - 1);
        end else begin
          bus.Src_Valid[i] = 1'b0;
          bus.Src_Last[i]  = 1'b0;
        end
      end
      @(negedge Clk);
      for (int i = 0; i < NSrc; i++) acc[i] = bus.Src_Valid[i] & bus.Src_Ready[i];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_len;
    n_vec   = 0;
    n_err   = 0;
    tx_auto = 1'b1;
    for (int i = 0; i < NSrc; i++) begin
      go_seq[i]   = 0;
      gap_en[i]   = 1'b0;
      src_len[i]  = 0;
      src_base[i] = 8'h00;
    end
    clr_mon();
    Rstn = 1'b0;

    // Reset state
    repeat (3) @(posedge Clk);
    #2;
    check_eq("rst_gnt", bus.Src_Gnt, 0);
    check_eq("rst_ready", bus.Src_Ready, 0);
    check_eq("rst_byte", bus.Eth_Byte, 0);
    check_eq("rst_valid", bus.Eth_Byte_Valid, 0);
    check_eq("rst_pkt", bus.Eth_Pkt_Rdy, 0);
    check_eq("rst_trunc", bus.Trunc_Err, 0);
    check_eq("rst_tmo", bus.Tx_Timeout, 0);
    Rstn = 1'b1;
    clr_mon();

    // Single 40-byte frame from source 0
    src_base[0] = 8'h01;
    src_len[0]  = 40;
    go_seq[0]++;
    wait_pkt(1, 500, "t1_wait_pkt");
    check_eq("t1_gnt0", glog(0), 0);
    check_eq("t1_len", rx_q.size(), 40);
    for (int i = 0; i < 40; i++) check_eq($sformatf("t1_byte%0d", i), rxb(i), i + 1);
    check_eq("t1_contig", last_vld_cyc - first_vld_cyc, 39);
    check_eq("t1_pkt_lag", pkt_lag, 1);
    check_eq("t1_trunc", trunc_cnt, 0);
    check_eq("t1_tmo", tmo_cnt, 0);

    // Round-robin: both request, source 0 has a second frame queued
    do_reset();
    gap_en[1]   = 1'b1;
    src_base[0] = 8'h40;
    src_len[0]  = 60;
    src_base[1] = 8'h80;
    src_len[1]  = 60;
    go_seq[0] += 2;
    go_seq[1] += 1;
    wait_pkt(3, 2000, "t2_wait_pkt");
    check_eq("t2_order0", glog(0), 0);
    check_eq("t2_order1", glog(1), 1);
    check_eq("t2_order2", glog(2), 0);
    check_eq("t2_ifg1", gcyc(1) - fcyc(0), IfgCycles + 1);
    check_eq("t2_ifg2", gcyc(2) - fcyc(1), IfgCycles + 1);
    check_eq("t2_len", rx_q.size(), 180);
    check_eq("t2_b0", rxb(0), 32'h40);
    check_eq("t2_b59", rxb(59), 32'h7b);
    check_eq("t2_b60", rxb(60), 32'h80);
    check_eq("t2_b119", rxb(119), 32'hbb);
    check_eq("t2_b120", rxb(120), 32'h40);
    check_eq("t2_pkt_lag", pkt_lag, 1);
    gap_en[1] = 1'b0;

    // Truncation at MAX_LEN
    do_reset();
    src_base[0] = 8'h10;
    src_len[0]  = 80;
    go_seq[0]++;
    wait_pkt(1, 500, "t3_wait_pkt");
    check_eq("t3_len", rx_q.size(), MaxLen);
    check_eq("t3_b63", rxb(63), 32'h4f);
    check_eq("t3_trunc_cnt", trunc_cnt, 1);
    check_eq("t3_trunc_when", trunc_cyc - last_vld_cyc, 0);
    check_eq("t3_gnt_fall", gnt_fall_cyc - last_vld_cyc, 0);
    check_eq("t3_pkt_lag", pkt_lag, 1);

    // Short frame: padded only when padding is compiled in
    do_reset();
    src_base[0] = 8'ha0;
    src_len[0]  = 10;
    go_seq[0]++;
    wait_pkt(1, 300, "t4_wait_pkt");
`ifdef ETH_TX_ARB_PAD_EN
    exp_len = MinLen;
    check_eq("t4_pad10", rxb(10), 0);
    check_eq("t4_pad45", rxb(45), 0);
`else
    exp_len = 10;
`endif
    check_eq("t4_len", rx_q.size(), exp_len);
    check_eq("t4_b9", rxb(9), 32'ha9);
    check_eq("t4_contig", last_vld_cyc - first_vld_cyc, exp_len - 1);
    check_eq("t4_pkt_lag", pkt_lag, 1);

    // Start timeout: eth_tx never raises Tx_Busy
    do_reset();
    tx_auto     = 1'b0;
    src_base[0] = 8'h30;
    src_len[0]  = 12;
    go_seq[0]++;
    wait_pkt(1, 300, "t5_wait_pkt");
    src_base[1] = 8'h55;
    src_len[1]  = 5;
    go_seq[1]++;
    wait_tmo(200, "t5_wait_tmo");
    check_eq("t5_tmo_delay", tmo_cyc - pkt_cyc, TxStartTo);
    wait_gnts(2, 300, "t5_wait_gnt");
    check_eq("t5_next_src", glog(1), 1);
    check_eq("t5_ifg", gcyc(1) - tmo_cyc, IfgCycles);
    tx_auto = 1'b1;
    wait_pkt(2, 300, "t5_wait_pkt2");
    check_eq("t5_len", rx_q.size(), 17);
    check_eq("t5_b12", rxb(12), 32'h55);
    check_eq("t5_tmo_cnt", tmo_cnt, 1);

    // Reset in the middle of a frame
    do_reset();
    src_base[0] = 8'h01;
    src_len[0]  = 50;
    go_seq[0]++;
    wait_rx(20, 300, "t6_wait_rx");
    Rstn = 1'b0;
    #1;
    check_eq("t6_gnt", bus.Src_Gnt, 0);
    check_eq("t6_ready", bus.Src_Ready, 0);
    check_eq("t6_valid", bus.Eth_Byte_Valid, 0);
    check_eq("t6_byte", bus.Eth_Byte, 0);
    check_eq("t6_pkt", bus.Eth_Pkt_Rdy, 0);
    repeat (2) @(posedge Clk);
    #2;
    Rstn = 1'b1;
    clr_mon();
    go_seq[0]++;
    go_seq[1]++;
    wait_pkt(1, 500, "t6_wait_pkt");
    check_eq("t6_first_src", glog(0), 0);
    check_eq("t6_len", rx_q.size(), 50);
    check_eq("t6_b0", rxb(0), 32'h01);
    check_eq("t6_b49", rxb(49), 32'h32);
    check_eq("t6_trunc", trunc_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
